// File: rtl/pcileech_ft601_rx_unpack.sv
// Receive unpacker: drops filler DWORDs, pairs DWORDs into {HI, LO} words, times out
// orphaned LO halves and buffers completed words in a small FWFT queue.
module pcileech_ft601_rx_unpack #(
  parameter logic [31:0] PARAM_FILLER  = 32'h66665555,
  parameter int          PARAM_TIMEOUT = 1024,
  parameter int          PARAM_DEPTH   = 4,
  parameter int          PARAM_AFULL   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] din,
  input  logic        din_valid,
  output logic        almost_full,
  output logic [63:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic [15:0] cnt_filler,
  output logic [15:0] cnt_drop
);

  localparam int AW = (PARAM_DEPTH > 1) ? $clog2(PARAM_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [15:0]   TIMER_LAST = 16'(PARAM_TIMEOUT - 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(PARAM_DEPTH);
  localparam logic [CW-1:0] AFULL_CNT  = CW'(PARAM_AFULL);

  typedef enum logic {S_LO, S_HI} state_t;

  state_t        state, state_nxt;
  logic [31:0]   lo, lo_nxt;
  logic [15:0]   timer, timer_nxt;
  logic          push, filler_hit, timeout_hit;

  logic [63:0]   mem [PARAM_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic          pop, accept, overflow;

  always_comb begin
    state_nxt   = state;
    lo_nxt      = lo;
    timer_nxt   = timer;
    push        = 1'b0;
    filler_hit  = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      S_LO: begin
        if (din_valid) begin
          if (din == PARAM_FILLER) begin
            filler_hit = 1'b1;
          end else begin
            lo_nxt    = din;
            timer_nxt = 16'd0;
            state_nxt = S_HI;
          end
        end
      end
      S_HI: begin
        // A DWORD arriving on the expiry cycle still completes the pair.
        if (din_valid) begin
          push      = 1'b1;
          state_nxt = S_LO;
        end else if (timer == TIMER_LAST) begin
          timeout_hit = 1'b1;
          state_nxt   = S_LO;
        end else begin
          timer_nxt = timer + 16'd1;
        end
      end
      default: state_nxt = S_LO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_LO;
      lo    <= 32'd0;
      timer <= 16'd0;
    end else begin
      state <= state_nxt;
      lo    <= lo_nxt;
      timer <= timer_nxt;
    end
  end

  // A same-cycle pop makes room, so a full queue still accepts the push.
  assign dout_valid = (count != '0);
  assign pop        = dout_valid & dout_ready;
  assign accept     = push & ((count != FULL_CNT) | pop);
  assign overflow   = push & ~accept;
  assign dout       = dout_valid ? mem[rd_ptr] : 64'h0;

  always_comb begin
    count_nxt = count;
    if (accept && !pop) begin
      count_nxt = count + CW'(1);
    end else if (!accept && pop) begin
      count_nxt = count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= {din, lo};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      almost_full <= 1'b0;
      cnt_filler  <= 16'd0;
      cnt_drop    <= 16'd0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);
      count       <= count_nxt;
      almost_full <= (count_nxt >= AFULL_CNT);
      if (filler_hit && cnt_filler != 16'hFFFF) cnt_filler <= cnt_filler + 16'd1;
      if ((timeout_hit || overflow) && cnt_drop != 16'hFFFF) cnt_drop <= cnt_drop + 16'd1;
    end
  end

endmodule
